// File: rtl/ftdi_cmd_parser.sv
// ftdi_cmd_parser: decodes register-access packets from the FTDI RX byte stream,
// runs one Wishbone-classic transaction per packet, and returns response bytes on TX.
// Latency: the bus cycle starts the cycle after the last packet byte. The first response byte follows ack by one cycle.
// Backpressure: RX is held off (o_rx_ready=0) during BUS/RESP, and TX bytes are held stable until i_tx_ready.
//
// Ports: i_clk/i_rst (sync, active-high); RX stream i_rx_data/i_rx_valid/o_rx_ready;
//        TX stream o_tx_data/o_tx_valid/i_tx_ready; Wishbone master o_wb_* / i_wb_dat / i_wb_ack;
//        o_err pulses for one cycle on a bad opcode (or an inter-byte timeout drop).
// Optional: define CMD_PARSER_TIMEOUT_EN to drop partial packets after TIMEOUT_CYCLES idle cycles.
module ftdi_cmd_parser #(
    parameter int ADDR_W         = 8,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [7:0]        i_rx_data,
    input  logic              i_rx_valid,
    output logic              o_rx_ready,
    output logic [7:0]        o_tx_data,
    output logic              o_tx_valid,
    input  logic              i_tx_ready,
    output logic              o_wb_cyc,
    output logic              o_wb_stb,
    output logic              o_wb_we,
    output logic [ADDR_W-1:0] o_wb_adr,
    output logic [DATA_W-1:0] o_wb_dat,
    input  logic [DATA_W-1:0] i_wb_dat,
    input  logic              i_wb_ack,
    output logic              o_err
);

    localparam int AB = ADDR_W / 8;
    localparam int DB = DATA_W / 8;
    localparam logic [2:0] ADDR_LAST = 3'(AB - 1);
    localparam logic [2:0] DATA_LAST = 3'(DB - 1);
    localparam logic [2:0] RD_LAST   = 3'(DB);      // opcode echo + DB data bytes

    localparam logic [7:0] OP_WR   = 8'h01;
    localparam logic [7:0] OP_RD   = 8'h02;
    localparam logic [7:0] RSP_WR  = 8'hA1;
    localparam logic [7:0] RSP_RD  = 8'hA2;
    localparam logic [7:0] RSP_BAD = 8'hEE;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_ADDR = 3'd1,
        S_DATA = 3'd2,
        S_BUS  = 3'd3,
        S_RESP = 3'd4
    } state_t;

    state_t            state, state_n;
    logic [2:0]        cnt;
    logic              is_write;
    logic [7:0]        resp_code;
    logic [ADDR_W-1:0] adr_q;
    logic [DATA_W-1:0] wdat_q;
    logic [DATA_W-1:0] rdat_q;
    logic              err_q, err_n;
    logic              rx_fire, tx_fire;
    logic [2:0]        resp_last;
    logic [7:0]        tx_byte;

    assign o_rx_ready = (state == S_IDLE) || (state == S_ADDR) || (state == S_DATA);
    assign o_tx_valid = (state == S_RESP);
    assign o_wb_cyc   = (state == S_BUS);
    assign o_wb_stb   = (state == S_BUS);
    assign o_wb_we    = (state == S_BUS) && is_write;
    assign o_wb_adr   = adr_q;
    assign o_wb_dat   = wdat_q;
    assign o_err      = err_q;
    assign o_tx_data  = tx_byte;

    assign rx_fire   = o_rx_ready && i_rx_valid;
    assign tx_fire   = o_tx_valid && i_tx_ready;
    assign resp_last = (resp_code == RSP_RD) ? RD_LAST : 3'd0;

`ifdef CMD_PARSER_TIMEOUT_EN
    localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_CYCLES - 1);
    logic [31:0] tmo_cnt;

    // Counts idle cycles inside a partially received packet.
    always_ff @(posedge i_clk) begin
        if (i_rst || rx_fire || !((state == S_ADDR) || (state == S_DATA))) begin
            tmo_cnt <= '0;
        end else begin
            tmo_cnt <= tmo_cnt + 32'd1;
        end
    end
`else
    logic unused_tmo;
    assign unused_tmo = (TIMEOUT_CYCLES != 0);
`endif

    always_comb begin
        state_n = state;
        err_n   = 1'b0;
        case (state)
            S_IDLE: begin
                if (rx_fire) begin
                    if ((i_rx_data == OP_WR) || (i_rx_data == OP_RD)) begin
                        state_n = S_ADDR;
                    end else begin
                        state_n = S_RESP;
                        err_n   = 1'b1;
                    end
                end
            end
            S_ADDR: if (rx_fire && (cnt == ADDR_LAST)) state_n = is_write ? S_DATA : S_BUS;
            S_DATA: if (rx_fire && (cnt == DATA_LAST)) state_n = S_BUS;
            S_BUS:  if (i_wb_ack) state_n = S_RESP;
            S_RESP: if (tx_fire && (cnt == resp_last)) state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
`ifdef CMD_PARSER_TIMEOUT_EN
        if (((state == S_ADDR) || (state == S_DATA)) && !rx_fire && (tmo_cnt == TMO_LAST)) begin
            state_n = S_IDLE;
            err_n   = 1'b1;
        end
`endif
    end

    // Response byte 0 is the status code; bytes 1..DB are read data, LSB first.
    always_comb begin
        tx_byte = 8'h00;
        if (state == S_RESP) begin
            tx_byte = resp_code;
            for (int i = 0; i < DB; i++) begin
                if (cnt == 3'(i + 1)) tx_byte = rdat_q[8*i +: 8];
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state     <= S_IDLE;
            cnt       <= 3'd0;
            is_write  <= 1'b0;
            resp_code <= 8'h00;
            adr_q     <= '0;
            wdat_q    <= '0;
            rdat_q    <= '0;
            err_q     <= 1'b0;
        end else begin
            state <= state_n;
            err_q <= err_n;
            // The byte index restarts on every state change.
            if (state_n != state) begin
                cnt <= 3'd0;
            end else if (rx_fire || tx_fire) begin
                cnt <= cnt + 3'd1;
            end
            case (state)
                S_IDLE: begin
                    if (rx_fire) begin
                        is_write  <= (i_rx_data == OP_WR);
                        resp_code <= (i_rx_data == OP_WR) ? RSP_WR :
                                     (i_rx_data == OP_RD) ? RSP_RD : RSP_BAD;
                    end
                end
                S_ADDR: begin
                    if (rx_fire) begin
                        for (int i = 0; i < AB; i++) begin
                            if (cnt == 3'(i)) adr_q[8*i +: 8] <= i_rx_data;
                        end
                    end
                end
                S_DATA: begin
                    if (rx_fire) begin
                        for (int i = 0; i < DB; i++) begin
                            if (cnt == 3'(i)) wdat_q[8*i +: 8] <= i_rx_data;
                        end
                    end
                end
                S_BUS: if (i_wb_ack && !is_write) rdat_q <= i_wb_dat;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ftdi_cmd_parser.sv
module tb_ftdi_cmd_parser;
    localparam int ADDR_W = 8;
    localparam int DATA_W = 32;
    localparam int AB = ADDR_W / 8;
    localparam int DB = DATA_W / 8;

    typedef struct packed {
        logic        we;
        logic [7:0]  adr;
        logic [31:0] dat;
    } bus_t;

    logic              clk = 1'b0;
    logic              rst;
    logic [7:0]        i_rx_data;
    logic              i_rx_valid;
    logic              o_rx_ready;
    logic [7:0]        o_tx_data;
    logic              o_tx_valid;
    logic              i_tx_ready;
    logic              o_wb_cyc, o_wb_stb, o_wb_we;
    logic [ADDR_W-1:0] o_wb_adr;
    logic [DATA_W-1:0] o_wb_dat;
    logic [DATA_W-1:0] wb_rdat;
    logic              wb_ack;
    logic              o_err;

    always #5 clk = ~clk;

    ftdi_cmd_parser #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_CYCLES(16)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_rx_data(i_rx_data), .i_rx_valid(i_rx_valid), .o_rx_ready(o_rx_ready),
        .o_tx_data(o_tx_data), .o_tx_valid(o_tx_valid), .i_tx_ready(i_tx_ready),
        .o_wb_cyc(o_wb_cyc), .o_wb_stb(o_wb_stb), .o_wb_we(o_wb_we),
        .o_wb_adr(o_wb_adr), .o_wb_dat(o_wb_dat), .i_wb_dat(wb_rdat),
        .i_wb_ack(wb_ack), .o_err(o_err)
    );

    int checks = 0;
    int errors = 0;

    // Behavioural model: the memory as the host sees it, pending expectations, logs.
    logic [31:0] model_mem[256];
    logic [31:0] slave_mem[256];
    logic [7:0]  pkt[$];
    logic [7:0]  exp_tx[$];
    bus_t        exp_bus[$];
    bus_t        bus_log[$];
    logic [7:0]  tx_log[$];
    int          bad_cnt = 0, err_cnt = 0, tmo_drops = 0;

    int tx_mode = 0;      // 0: always ready, 1: random, 2: toggle
    int ack_delay = 0;    // <0: random 0..3
    bit stray_en = 0;
    int gap_max = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic abort(input string name);
        checks++;
        errors++;
        $display("FAIL %s: wait bound expired", name);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    endtask

    // Packet rules: opcode 01 = write (addr, data), 02 = read (addr), anything else is rejected.
    task automatic model_rx(input logic [7:0] b);
        logic [7:0]  adr;
        logic [31:0] dat;
        bus_t        t;
        pkt.push_back(b);
        if (pkt[0] != 8'h01 && pkt[0] != 8'h02) begin
            exp_tx.push_back(8'hEE);
            bad_cnt++;
            pkt.delete();
        end else if (pkt.size() == ((pkt[0] == 8'h01) ? 1 + AB + DB : 1 + AB)) begin
            adr = pkt[1];
            dat = 32'h0;
            if (pkt[0] == 8'h01) begin
                for (int i = 0; i < DB; i++) dat = dat | (32'(pkt[1 + AB + i]) << (8 * i));
                model_mem[adr] = dat;
                exp_tx.push_back(8'hA1);
            end else begin
                exp_tx.push_back(8'hA2);
                for (int i = 0; i < DB; i++) exp_tx.push_back(8'((model_mem[adr] >> (8 * i)) & 32'hFF));
            end
            t.we  = (pkt[0] == 8'h01);
            t.adr = adr;
            t.dat = dat;
            exp_bus.push_back(t);
            pkt.delete();
        end
    endtask

    // Compare process: every cycle out of reset.
    bit         exp_cyc, exp_txv, prev_stall, prev_err;
    logic [7:0] prev_tx;
    bus_t       seen;
    always @(negedge clk) begin
        if (!rst) begin
            exp_cyc = (exp_bus.size() != 0);
            exp_txv = (exp_bus.size() == 0) && (exp_tx.size() != 0);
            check("rx_ready", o_rx_ready, !exp_cyc && !exp_txv);
            check("wb_cyc", o_wb_cyc, exp_cyc);
            check("wb_stb", o_wb_stb, exp_cyc);
            check("tx_valid", o_tx_valid, exp_txv);
            if (exp_cyc && o_wb_cyc) begin
                check("wb_we", o_wb_we, exp_bus[0].we);
                check("wb_adr", o_wb_adr, exp_bus[0].adr);
                if (exp_bus[0].we) check("wb_dat", o_wb_dat, exp_bus[0].dat);
                if (wb_ack) begin
                    seen.we = o_wb_we; seen.adr = o_wb_adr; seen.dat = o_wb_dat;
                    bus_log.push_back(seen);
                    void'(exp_bus.pop_front());
                end
            end
            if (prev_stall) check("tx_hold", o_tx_data, prev_tx);
            if (exp_txv && o_tx_valid) begin
                check("tx_data", o_tx_data, exp_tx[0]);
                if (i_tx_ready) begin
                    tx_log.push_back(o_tx_data);
                    void'(exp_tx.pop_front());
                end
            end
            prev_stall = o_tx_valid && !i_tx_ready;
            prev_tx = o_tx_data;
            if (o_err) begin
                err_cnt++;
                check("err_one_cycle", prev_err, 1'b0);
            end
            prev_err = o_err;
            if (o_rx_ready && i_rx_valid) model_rx(i_rx_data);
        end else begin
            prev_stall = 0;
            prev_err = 0;
        end
    end

    // Wishbone slave with its own memory; also throws stray acks while idle.
    bit          real_ack = 0, started = 0, cap_we;
    logic [7:0]  cap_adr;
    logic [31:0] cap_dat;
    int          wait_cnt = 0, cur_delay = 0;
    initial begin
        wb_ack = 0;
        wb_rdat = 0;
        forever begin
            @(posedge clk); #1;
            if (real_ack && cap_we) slave_mem[cap_adr] = cap_dat;
            wb_ack = 0;
            real_ack = 0;
            if (rst || !o_wb_cyc) begin
                wait_cnt = 0;
                started = 0;
                if (!rst && stray_en && $urandom_range(0, 3) == 0) begin
                    wb_ack = 1;
                    wb_rdat = $urandom;
                end
            end else begin
                if (!started) begin
                    started = 1;
                    cur_delay = (ack_delay < 0) ? int'($urandom_range(0, 3)) : ack_delay;
                end
                if (wait_cnt >= cur_delay) begin
                    wb_ack = 1; real_ack = 1;
                    cap_we = o_wb_we; cap_adr = o_wb_adr; cap_dat = o_wb_dat;
                    wb_rdat = o_wb_we ? $urandom : slave_mem[o_wb_adr];
                    started = 0;
                    wait_cnt = 0;
                end else begin
                    wait_cnt++;
                end
            end
        end
    end

    // TX sink.
    initial begin
        i_tx_ready = 1;
        forever begin
            @(posedge clk); #1;
            case (tx_mode)
                1: i_tx_ready = ($urandom_range(0, 9) < 6);
                2: i_tx_ready = ~i_tx_ready;
                default: i_tx_ready = 1;
            endcase
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        i_rx_data = b;
        i_rx_valid = 1;
        do begin
            @(negedge clk);
            n++;
        end while (!o_rx_ready && n < 2000);
        if (!o_rx_ready) abort("rx_accept");
        @(posedge clk); #1;
        i_rx_valid = 0;
        i_rx_data = 8'($urandom);
        repeat ($urandom_range(0, gap_max)) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic send_wr(input logic [7:0] adr, input logic [31:0] dat);
        send_byte(8'h01);
        send_byte(adr);
        for (int i = 0; i < DB; i++) send_byte(dat[8*i +: 8]);
    endtask

    task automatic send_rd(input logic [7:0] adr);
        send_byte(8'h02);
        send_byte(adr);
    endtask

    task automatic wait_quiet();
        int n;
        n = 0;
        while ((exp_bus.size() != 0 || exp_tx.size() != 0) && n < 3000) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 3000) abort("wait_quiet");
        repeat (2) begin
            @(posedge clk); #1;
        end
    endtask

    // Literal expectation for the last read response: A2 then data LSB first.
    task automatic check_read_tail(input string name, input logic [31:0] d);
        int base;
        base = tx_log.size() - 5;
        check({name, "_op"}, tx_log[base], 8'hA2);
        for (int i = 0; i < 4; i++) check({name, "_byte"}, tx_log[base + 1 + i], d[8*i +: 8]);
    endtask

    int         n0, nt, nb;
    logic [31:0] v;
    logic [7:0]  b;
    initial begin
        rst = 1;
        i_rx_valid = 0;
        i_rx_data = 0;
        for (int i = 0; i < 256; i++) begin
            v = $urandom;
            model_mem[i] = v;
            slave_mem[i] = v;
        end
        repeat (3) @(posedge clk);
        #1 rst = 0;
        @(negedge clk);
        check("rst_rx_ready", o_rx_ready, 1'b1);
        check("rst_cyc", o_wb_cyc, 1'b0);
        check("rst_tx_valid", o_tx_valid, 1'b0);
        check("rst_err", o_err, 1'b0);
        check("rst_adr", o_wb_adr, 8'h00);
        check("rst_dat", o_wb_dat, 32'h0);
        check("rst_tx_data", o_tx_data, 8'h00);
        @(posedge clk); #1;

        // Write 0x12345678 to 0x10, slow ack.
        ack_delay = 3;
        send_wr(8'h10, 32'h12345678);
        wait_quiet();
        check("wr_resp", tx_log[tx_log.size() - 1], 8'hA1);
        check("wr_bus_we", bus_log[bus_log.size() - 1].we, 1'b1);
        check("wr_bus_adr", bus_log[bus_log.size() - 1].adr, 8'h10);
        check("wr_bus_dat", bus_log[bus_log.size() - 1].dat, 32'h12345678);

        // Read 0x2C, immediate ack.
        slave_mem[8'h2C] = 32'hDEADBEEF;
        model_mem[8'h2C] = 32'hDEADBEEF;
        ack_delay = 0;
        send_rd(8'h2C);
        wait_quiet();
        check_read_tail("rd", 32'hDEADBEEF);

        // Bad opcode followed by a normal read.
        n0 = err_cnt;
        send_byte(8'h55);
        send_rd(8'h05);
        wait_quiet();
        check("bad_resp", tx_log[tx_log.size() - 6], 8'hEE);
        check("bad_err_pulses", err_cnt - n0, 1);
        check_read_tail("after_bad", slave_mem[8'h05]);

        // Read under toggling TX backpressure.
        tx_mode = 2;
        nt = tx_log.size();
        send_rd(8'h2C);
        wait_quiet();
        tx_mode = 0;
        check("bp_count", tx_log.size() - nt, 5);
        check_read_tail("bp", 32'hDEADBEEF);

        // Reset in the middle of the data bytes.
        send_byte(8'h01);
        send_byte(8'h10);
        send_byte(8'h78);
        rst = 1;
        pkt.delete();
        @(posedge clk); #1;
        rst = 0;
        nt = tx_log.size();
        nb = bus_log.size();
        @(negedge clk);
        check("mid_rst_adr", o_wb_adr, 8'h00);
        check("mid_rst_rx_ready", o_rx_ready, 1'b1);
        repeat (5) @(posedge clk);
        #1;
        check("mid_rst_no_tx", tx_log.size(), nt);
        check("mid_rst_no_bus", bus_log.size(), nb);
        send_rd(8'h10);
        wait_quiet();
        check_read_tail("post_rst", 32'h12345678);

`ifdef CMD_PARSER_TIMEOUT_EN
        // Stall mid-packet past the idle limit.
        n0 = err_cnt;
        send_byte(8'h01);
        send_byte(8'h10);
        repeat (20) @(posedge clk);
        #1;
        pkt.delete();
        tmo_drops++;
        check("tmo_err_pulses", err_cnt - n0, 1);
        send_rd(8'h10);
        wait_quiet();
        check_read_tail("post_tmo", 32'h12345678);
`endif

        // Randomised traffic.
        tx_mode = 1;
        ack_delay = -1;
        stray_en = 1;
        gap_max = 2;
        for (int k = 0; k < 80; k++) begin
            int r;
            r = $urandom_range(0, 9);
            b = 8'($urandom_range(0, 15));
            if (r < 4) begin
                send_wr(b, $urandom);
            end else if (r < 8) begin
                send_rd(b);
            end else begin
                do b = 8'($urandom); while (b == 8'h01 || b == 8'h02);
                send_byte(b);
            end
        end
        wait_quiet();
        check("err_total", err_cnt, bad_cnt + tmo_drops);
        check("pending_empty", exp_tx.size() + exp_bus.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ftdi_cmd_parser.md
Name: ftdi_cmd_parser

Overview:
Command-layer stage directly downstream of the FTDI SyncFIFO byte interface, running in the FTDI CLKOUT domain. Consumes the RX byte stream (FTDI->FPGA), decodes fixed-format register-access packets and issues single Wishbone-classic transactions. Returns response bytes on the TX byte stream (FPGA->FTDI). One command is in flight at a time.

Parameters:
ADDR_W, 8, register address width; must be a multiple of 8, max 32; sent as ADDR_W/8 bytes, LSB first
DATA_W, 32, register data width; must be a multiple of 8, max 32; sent as DATA_W/8 bytes, LSB first
TIMEOUT_CYCLES, 1000000, inter-byte idle limit used only when CMD_PARSER_TIMEOUT_EN is defined

Ports:
i_clk  in  1  system clock (FTDI CLKOUT domain)
i_rst  in  1  reset: synchronous, active-high
i_rx_data  in  8  RX byte from the FTDI stage
i_rx_valid  in  1  RX byte valid
o_rx_ready  out  1  parser accepts RX byte
o_tx_data  out  8  response byte to the FTDI stage
o_tx_valid  out  1  response byte valid
i_tx_ready  in  1  FTDI stage accepts the byte
o_wb_cyc  out  1  bus cycle
o_wb_stb  out  1  bus strobe
o_wb_we  out  1  1=write
o_wb_adr  out  ADDR_W  bus address
o_wb_dat  out  DATA_W  write data
i_wb_dat  in  DATA_W  read data
i_wb_ack  in  1  bus acknowledge
o_err  out  1  one-cycle pulse on bad opcode or timeout drop

Behaviour:
- Stream transfer: a byte moves when valid&&ready are both 1 on the rising edge of i_clk. o_tx_valid/o_tx_data are held stable until accepted.
- Packet formats (host->FPGA):
  - WRITE: 0x01, address bytes, data bytes.
  - READ: 0x02, address bytes.
- Responses (FPGA->host):
  - WRITE: 0xA1.
  - READ: 0xA2, then DATA_W/8 data bytes, LSB first.
  - Unknown opcode: 0xEE.
- States:
  - IDLE: o_rx_ready=1; on opcode byte go to ADDR if 0x01/0x02; otherwise latch response 0xEE, pulse o_err, go to RESP.
  - ADDR: o_rx_ready=1; shift bytes into address, LSB first; after ADDR_W/8 bytes go to DATA if write, else BUS.
  - DATA: o_rx_ready=1; collect DATA_W/8 bytes into the write register, then go to BUS.
  - BUS: o_wb_cyc=o_wb_stb=1, o_wb_we=write; on the first cycle with i_wb_ack=1, latch i_wb_dat (read only), go to RESP. cyc/stb drop the next cycle. No bus timeout: a stuck slave holds BUS.
  - RESP: o_tx_valid=1; step the byte index on each accepted byte; after the last byte go to IDLE.
- o_rx_ready=0 in BUS and RESP; no RX bytes are consumed or lost while a command is executing.
- Byte counter width is 3 bits and covers up to 5 response bytes. The counter clears on every state entry.
- i_wb_ack outside BUS is ignored.
- Latency: the bus cycle starts the cycle after the last packet byte is accepted. The first response byte is valid the cycle after ack.
- Reset (at any point, including mid-packet, mid-bus or mid-response):
  - state goes to IDLE; all outputs go to 0 except o_rx_ready=1 once in IDLE.
  - o_wb_adr, o_wb_dat and o_tx_data go to 0.
  - A partially sent response is abandoned; a bus cycle in progress is dropped.
- o_rx_ready is combinational from state only; it has no dependency on i_rx_valid.

Optional Feature:
- Macro: CMD_PARSER_TIMEOUT_EN.
- Defined:
  - A counter runs while in ADDR or DATA and is cleared on each accepted RX byte.
  - On reaching TIMEOUT_CYCLES-1 the partial packet is dropped, o_err pulses for one cycle, and the state returns to IDLE.
  - No response byte is sent.
- Undefined:
  - No counter; the parser waits indefinitely for the remaining bytes.
  - o_err pulses only on a bad opcode.

Test Plan:
- Write: RX 01 10 78 56 34 12 -> one bus cycle with we=1, adr=0x10, dat=0x12345678; ack after 3 cycles -> TX A1.
- Read: RX 02 2C, slave returns 0xDEADBEEF with immediate ack -> TX A2 EF BE AD DE; o_rx_ready=0 until the last byte is accepted.
- Bad opcode: RX 55 02 05 -> TX EE with o_err pulse; then a normal read of addr 0x05 completes.
- Backpressure: i_tx_ready toggling 1/0 during a read response -> all 5 bytes arrive exactly once, in order, with data stable while stalled.
- Reset mid-DATA: after bytes 01 10 78, assert i_rst for 1 cycle -> no bus cycle, no TX; next packet 02 10 parses correctly.
- With CMD_PARSER_TIMEOUT_EN and TIMEOUT_CYCLES=16: RX 01 10 then idle for 16 cycles -> o_err pulse, IDLE; then 02 10 -> A2 plus 4 data bytes.
